// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the UART command parser slice.
// The optional reply path is enabled with the UART_CMD_ACK_EN macro.
package uart_cmd_parser_pkg;

  localparam int         DATA_W          = 16;
  localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
  localparam int         TIMEOUT_DEFAULT = 100000;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  localparam logic [1:0] ADDR_KP = 2'd0;
  localparam logic [1:0] ADDR_KI = 2'd1;
  localparam logic [1:0] ADDR_KD = 2'd2;
  localparam logic [1:0] ADDR_SP = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_D0,
    GET_D1,
    GET_CHK
  } parseState_t;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / parameter-out bundle between the UART receiver, parser and PID core.
// UART_CMD_ACK_EN adds the reply handshake towards the UART transmitter.
interface uart_cmd_parser_if;
  import uart_cmd_parser_pkg::*;

  logic              data_rdy;
  logic [7:0]        data;
  logic [DATA_W-1:0] kp;
  logic [DATA_W-1:0] ki;
  logic [DATA_W-1:0] kd;
  logic [DATA_W-1:0] setpoint;
  logic              param_valid;
  logic [1:0]        param_addr;
  logic              frame_err;
  logic [7:0]        err_count;
`ifdef UART_CMD_ACK_EN
  logic              send;
  logic [7:0]        send_data;
  logic              send_rdy;

  modport master (
    output data_rdy, data, send_rdy,
    input  kp, ki, kd, setpoint, param_valid, param_addr, frame_err, err_count,
           send, send_data
  );
  modport slave (
    input  data_rdy, data, send_rdy,
    output kp, ki, kd, setpoint, param_valid, param_addr, frame_err, err_count,
           send, send_data
  );
`else
  modport master (
    output data_rdy, data,
    input  kp, ki, kd, setpoint, param_valid, param_addr, frame_err, err_count
  );
  modport slave (
    input  data_rdy, data,
    output kp, ki, kd, setpoint, param_valid, param_addr, frame_err, err_count
  );
`endif

endinterface

// File: rtl/uart_cmd_parser_rx_edge.sv
// Turns the receiver's level-style data_rdy into a single-cycle byte strobe,
// so a data_rdy held high for many cycles still yields exactly one byte.
module uart_rx_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic byte_stb
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign byte_stb = level & ~prev_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes SOF/ADDR/D0/D1/CHK frames into the PID parameter registers.
// Define UART_CMD_ACK_EN to return ACK/NAK bytes for every completed or aborted frame.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SOF         = SOF_DEFAULT,
  parameter int         TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input logic               clk_in,
  input logic               reset,
  uart_cmd_parser_if.slave  bus
);

  localparam int             TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYC - 1);

  parseState_t       state_q;
  logic [7:0]        addr_q, d0_q, d1_q;
  logic [TW-1:0]     timer_q;
  logic [DATA_W-1:0] kp_q, ki_q, kd_q, sp_q;
  logic              paramValid_q, frameErr_q;
  logic [1:0]        paramAddr_q;
  logic [7:0]        errCount_q, errCount_d;
  logic              byteStb, chkOk, timeoutHit, frameDone;

  uart_rx_edge u_edge (
    .clk      (clk_in),
    .rst      (reset),
    .level    (bus.data_rdy),
    .byte_stb (byteStb)
  );

  // A byte edge always beats a simultaneous timeout expiry.
  assign chkOk      = (bus.data == (addr_q ^ d0_q ^ d1_q)) && (addr_q[7:2] == 6'd0);
  assign timeoutHit = (state_q != IDLE) && !byteStb && (timer_q == T_LAST);
  assign frameDone  = byteStb && (state_q == GET_CHK);
  assign errCount_d = satInc(errCount_q);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      d0_q         <= '0;
      d1_q         <= '0;
      timer_q      <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      sp_q         <= '0;
      paramValid_q <= 1'b0;
      paramAddr_q  <= '0;
      frameErr_q   <= 1'b0;
      errCount_q   <= '0;
    end else begin
      paramValid_q <= 1'b0;
      frameErr_q   <= 1'b0;

      if (state_q == IDLE || byteStb || timeoutHit) timer_q <= '0;
      else                                          timer_q <= timer_q + 1'b1;

      if (byteStb) begin
        unique case (state_q)
          IDLE:     if (bus.data == SOF) state_q <= GET_ADDR;
          GET_ADDR: begin addr_q <= bus.data; state_q <= GET_D0;  end
          GET_D0:   begin d0_q   <= bus.data; state_q <= GET_D1;  end
          GET_D1:   begin d1_q   <= bus.data; state_q <= GET_CHK; end
          GET_CHK: begin
            state_q <= IDLE;
            if (chkOk) begin
              unique case (addr_q[1:0])
                ADDR_KP: kp_q <= {d1_q, d0_q};
                ADDR_KI: ki_q <= {d1_q, d0_q};
                ADDR_KD: kd_q <= {d1_q, d0_q};
                ADDR_SP: sp_q <= {d1_q, d0_q};
              endcase
              paramValid_q <= 1'b1;
              paramAddr_q  <= addr_q[1:0];
            end else begin
              frameErr_q <= 1'b1;
              errCount_q <= errCount_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (timeoutHit) begin
        state_q    <= IDLE;
        frameErr_q <= 1'b1;
        errCount_q <= errCount_d;
      end
    end
  end

  assign bus.kp          = kp_q;
  assign bus.ki          = ki_q;
  assign bus.kd          = kd_q;
  assign bus.setpoint    = sp_q;
  assign bus.param_valid = paramValid_q;
  assign bus.param_addr  = paramAddr_q;
  assign bus.frame_err   = frameErr_q;
  assign bus.err_count   = errCount_q;

`ifdef UART_CMD_ACK_EN
  logic       pending_q, send_q;
  logic [7:0] sendData_q, replyByte_d;

  assign replyByte_d = (frameDone && chkOk) ? ACK_BYTE : NAK_BYTE;

  // A fresh reply replaces any unsent one; send_data stays put through the pulse.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pending_q  <= 1'b0;
      send_q     <= 1'b0;
      sendData_q <= '0;
    end else begin
      send_q <= 1'b0;
      if (frameDone || timeoutHit) begin
        pending_q  <= 1'b1;
        sendData_q <= replyByte_d;
      end else if (pending_q && bus.send_rdy) begin
        send_q    <= 1'b1;
        pending_q <= 1'b0;
      end
    end
  end

  assign bus.send      = send_q;
  assign bus.send_data = sendData_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized frame traffic for uart_cmd_parser checked against a frame-level model.
// Build with UART_CMD_ACK_EN defined to also exercise the ACK/NAK reply path.
module tb_uart_cmd_parser;
  import uart_cmd_parser_pkg::*;

  localparam int         TCYC = 64;
  localparam logic [7:0] SOFB = 8'hA5;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.SOF(SOFB), .TIMEOUT_CYC(TCYC)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int testsRun    = 0;
  int testsFailed = 0;

  // Pulse monitor, sampled on the falling edge away from register updates
  int         pvSeen = 0, feSeen = 0, overlapSeen = 0;
  logic [1:0] lastAddr = 2'd0;
`ifdef UART_CMD_ACK_EN
  int         sendSeen = 0;
  logic [7:0] lastSend = 8'h00;
`endif

  always @(negedge clk_in) begin
    if (bus.param_valid) begin
      pvSeen++;
      lastAddr = bus.param_addr;
    end
    if (bus.frame_err) feSeen++;
    if (bus.param_valid && bus.frame_err) overlapSeen++;
`ifdef UART_CMD_ACK_EN
    if (bus.send) begin
      sendSeen++;
      lastSend = bus.send_data;
    end
`endif
  end

  // Frame-level reference model: collects the four bytes after SOF and judges the frame
  logic [15:0] mRegs [4];
  int          mErr = 0, mPv = 0, mFe = 0;
  logic [1:0]  mAddr = 2'd0;
  bit          mIn = 0;
  int          mN = 0;
  logic [7:0]  mBuf [4];

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mRegs[i] = 16'h0000;
    mErr = 0;
    mIn  = 0;
    mN   = 0;
  endtask

  task automatic modelError();
    mFe++;
    if (mErr < 255) mErr++;
  endtask

  task automatic modelFeed(input logic [7:0] b);
    if (!mIn) begin
      if (b == SOFB) begin
        mIn = 1;
        mN  = 0;
      end
    end else begin
      mBuf[mN] = b;
      mN++;
      if (mN == 4) begin
        mIn = 0;
        if ((mBuf[3] == (mBuf[0] ^ mBuf[1] ^ mBuf[2])) && (mBuf[0] < 8'd4)) begin
          mRegs[mBuf[0][1:0]] = {mBuf[2], mBuf[1]};
          mPv++;
          mAddr = mBuf[0][1:0];
        end else begin
          modelError();
        end
      end
    end
  endtask

  task automatic modelTimeout();
    if (mIn) begin
      mIn = 0;
      modelError();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk_in);
    #1;
    bus.data     = b;
    bus.data_rdy = 1'b1;
    repeat (hold) @(posedge clk_in);
    #1;
    bus.data_rdy = 1'b0;
    repeat (gap) @(posedge clk_in);
    modelFeed(b);
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] chk, input int gap);
    applyStimulus(SOFB, 1, gap);
    applyStimulus(a,   $urandom_range(1, 3), gap);
    applyStimulus(d0,  $urandom_range(1, 3), gap);
    applyStimulus(d1,  $urandom_range(1, 3), gap);
    applyStimulus(chk, $urandom_range(1, 3), gap);
  endtask

  task automatic waitTimeout();
    repeat (TCYC + 8) @(posedge clk_in);
    modelTimeout();
  endtask

  task automatic compareAll(input string tag);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput({tag, " kp"},        32'(bus.kp),        32'(mRegs[0]));
    checkOutput({tag, " ki"},        32'(bus.ki),        32'(mRegs[1]));
    checkOutput({tag, " kd"},        32'(bus.kd),        32'(mRegs[2]));
    checkOutput({tag, " setpoint"},  32'(bus.setpoint),  32'(mRegs[3]));
    checkOutput({tag, " err_count"}, 32'(bus.err_count), 32'(mErr));
    checkOutput({tag, " pv_pulses"}, 32'(pvSeen),        32'(mPv));
    checkOutput({tag, " fe_pulses"}, 32'(feSeen),        32'(mFe));
    checkOutput({tag, " last_addr"}, 32'(lastAddr),      32'(mAddr));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " kp"},          32'(bus.kp),          32'd0);
    checkOutput({tag, " ki"},          32'(bus.ki),          32'd0);
    checkOutput({tag, " kd"},          32'(bus.kd),          32'd0);
    checkOutput({tag, " setpoint"},    32'(bus.setpoint),    32'd0);
    checkOutput({tag, " param_valid"}, 32'(bus.param_valid), 32'd0);
    checkOutput({tag, " param_addr"},  32'(bus.param_addr),  32'd0);
    checkOutput({tag, " frame_err"},   32'(bus.frame_err),   32'd0);
    checkOutput({tag, " err_count"},   32'(bus.err_count),   32'd0);
  endtask

  logic [7:0] a, d0, d1, chk, b;
  int         kind, k;

  initial begin
    bus.data_rdy = 1'b0;
    bus.data     = 8'h00;
`ifdef UART_CMD_ACK_EN
    bus.send_rdy = 1'b0;
`endif
    modelReset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkAllZero("reset");
    reset = 1'b0;

    // Directed frames from the plan
    sendFrame(8'h01, 8'h34, 8'h12, 8'h27, 1);
    compareAll("good_ki");
    sendFrame(8'h03, 8'h00, 8'h10, 8'h00, 1);
    compareAll("bad_chk");
    applyStimulus(8'h00, 1, 1);
    applyStimulus(8'hFF, 1, 1);
    applyStimulus(8'h5A, 1, 1);
    compareAll("garbage");
    sendFrame(8'h04, 8'h11, 8'h22, 8'h37, 1);
    compareAll("bad_addr");

    // Held data_rdy must yield one SOF, so the following bytes form a clean frame
    applyStimulus(SOFB, 10, 2);
    applyStimulus(8'h02, 1, 1);
    applyStimulus(8'h34, 1, 1);
    applyStimulus(8'h12, 1, 1);
    applyStimulus(8'h24, 1, 1);
    compareAll("held_rdy");

    applyStimulus(SOFB, 1, 1);
    applyStimulus(8'h00, 1, 1);
    waitTimeout();
    compareAll("timeout");
    sendFrame(8'h00, 8'hFF, 8'h00, 8'hFF, 1);
    compareAll("after_timeout");

    // Slow but legal spacing, and SOF bytes used as payload
    sendFrame(8'h03, 8'h5C, 8'h7E, 8'h03 ^ 8'h5C ^ 8'h7E, TCYC / 2);
    compareAll("slow_frame");
    sendFrame(8'h00, SOFB, SOFB, 8'h00, 1);
    compareAll("sof_payload");

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a    = 8'($urandom_range(0, 3));
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      chk  = a ^ d0 ^ d1;
      case (kind)
        0: begin
          b = 8'($urandom);
          if (b == SOFB) b = 8'h5A;
          applyStimulus(b, $urandom_range(1, 3), $urandom_range(1, 3));
        end
        1: sendFrame(a, d0, d1, chk, $urandom_range(1, 3));
        2: sendFrame(a, d0, d1, chk ^ (8'h01 << $urandom_range(0, 7)), $urandom_range(1, 3));
        3: begin
          a = 8'($urandom_range(4, 255));
          sendFrame(a, d0, d1, a ^ d0 ^ d1, $urandom_range(1, 3));
        end
        default: begin
          k = $urandom_range(0, 3);
          applyStimulus(SOFB, 1, 1);
          for (int j = 0; j < k; j++) applyStimulus(8'($urandom), 1, 1);
          waitTimeout();
        end
      endcase
      compareAll($sformatf("rand%0d", i));
    end

    // Reset mid-frame throws the partial frame and all registers away
    applyStimulus(SOFB, 1, 1);
    applyStimulus(8'h02, 1, 1);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    modelReset();
    checkAllZero("mid_reset");
    @(negedge clk_in);
    reset = 1'b0;
    sendFrame(8'h02, 8'hAA, 8'h55, 8'hFD, 1);
    compareAll("after_reset");

`ifdef UART_CMD_ACK_EN
    sendFrame(8'h01, 8'h34, 8'h12, 8'h27, 1);
    compareAll("ack_frame");
    k = sendSeen;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("ack_held", 32'(sendSeen - k), 32'd0);
    bus.send_rdy = 1'b1;
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    bus.send_rdy = 1'b0;
    checkOutput("ack_count", 32'(sendSeen - k), 32'd1);
    checkOutput("ack_data",  32'(lastSend),     32'(ACK_BYTE));
    sendFrame(8'h03, 8'h00, 8'h10, 8'h00, 1);
    compareAll("nak_frame");
    bus.send_rdy = 1'b1;
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    bus.send_rdy = 1'b0;
    checkOutput("nak_count", 32'(sendSeen - k), 32'd2);
    checkOutput("nak_data",  32'(lastSend),     32'(NAK_BYTE));
`endif

    // Drive the error counter past its ceiling
    for (int i = 0; i < 260; i++) sendFrame(8'h08, 8'h00, 8'h00, 8'h08, 1);
    compareAll("saturate");
    checkOutput("pv_fe_overlap", 32'(overlapSeen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
